// File: rtl/dsp_acc_pkg.sv
// Shared types and helpers for the product accumulator.
package dsp_acc_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StPend} acc_state_e;

  // Full-precision width needed to sum len products of in_w bits.
  function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned len);
    return in_w + $clog2(len);
  endfunction

endpackage

// File: rtl/dsp_acc_fit.sv
// Reduces the full-precision group sum to the output width.
// Saturates when DSP_ACC_SAT_EN is defined, otherwise keeps the low bits.
module dsp_acc_fit #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned OUT_W = 40
) (
  input  logic [ACC_W-1:0] sum,
  output logic [OUT_W-1:0] res,
  output logic             sat
);

  if (OUT_W >= ACC_W) begin : g_wide
    assign res = OUT_W'(sum);
    assign sat = 1'b0;
  end else begin : g_narrow
`ifdef DSP_ACC_SAT_EN
    logic over;
    assign over = |sum[ACC_W-1:OUT_W];
    assign res  = over ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
    assign sat  = over;
`else
    // Upper bits are dropped on purpose when wrapping.
    logic [ACC_W-OUT_W-1:0] unused_hi;
    assign unused_hi = sum[ACC_W-1:OUT_W];
    assign res       = sum[OUT_W-1:0];
    assign sat       = 1'b0;
`endif
  end

endmodule

// File: rtl/dsp_product_accumulator.sv
// Sums ACC_LEN multiplier products per group behind a one-deep valid/ready output.
// Optional clamping of the result is enabled with the DSP_ACC_SAT_EN macro.
module dsp_product_accumulator
  import dsp_acc_pkg::*;
#(
  parameter int unsigned IN_W    = 38,
  parameter int unsigned ACC_LEN = 4,
  parameter int unsigned OUT_W   = 40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IN_W-1:0]            z_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       clear,
  output logic [OUT_W-1:0]           acc_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       sat,
  output logic [$clog2(ACC_LEN)-1:0] grp_cnt
);

  localparam int unsigned      ACC_W = acc_width(IN_W, ACC_LEN);
  localparam int unsigned      CNT_W = $clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(ACC_LEN - 1);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_out_q, acc_out_d;
  logic             out_valid_q, out_valid_d;
  logic             sat_q, sat_d;

  logic             is_last, accept, drain, final_acc;
  logic [ACC_W-1:0] sum;
  logic [OUT_W-1:0] fit_val;
  logic             fit_sat;

  assign is_last   = (cnt_q == LAST);
  // Only the closing product of a group needs a free output register.
  assign in_ready  = !(out_valid_q && !out_ready && is_last);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid_q && out_ready;
  assign final_acc = accept && is_last && !clear;

  // A new group (or a clear) starts from zero instead of the stale partial sum.
  assign sum = ((state_q == StAccum && !clear) ? acc_q : '0) + ACC_W'(z_in);

  dsp_acc_fit #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) u_fit (
    .sum(sum),
    .res(fit_val),
    .sat(fit_sat)
  );

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_out_d   = acc_out_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;

    if (clear) cnt_d = '0;
    if (accept) begin
      acc_d = sum;
      if (final_acc)  cnt_d = '0;
      else if (clear) cnt_d = CNT_W'(1);
      else            cnt_d = cnt_q + 1'b1;
    end

    if (drain) out_valid_d = 1'b0;
    if (final_acc) begin
      out_valid_d = 1'b1;
      acc_out_d   = fit_val;
      sat_d       = fit_sat;
    end
  end

  always_comb begin
    state_d = StIdle;
    if (cnt_d != '0)      state_d = StAccum;
    else if (out_valid_d) state_d = StPend;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign out_valid = out_valid_q;
  assign sat       = sat_q;
  assign grp_cnt   = cnt_q;

endmodule

// File: tb/tb_dsp_product_accumulator.sv
// Randomised and directed bench for dsp_product_accumulator against a group-sum model.
module tb_dsp_product_accumulator;

  localparam int unsigned IN_W    = 38;
  localparam int unsigned ACC_LEN = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [IN_W-1:0] z_in = '0;
  logic            in_valid = 1'b0;
  logic            clear = 1'b0;
  logic            out_ready = 1'b0;

  logic            in_ready, out_valid, sat;
  logic [39:0]     acc_out;
  logic [1:0]      grp_cnt;
  logic            in_ready_b, out_valid_b, sat_b;
  logic [37:0]     acc_out_b;
  logic [1:0]      grp_cnt_b;

  dsp_product_accumulator #(.IN_W(IN_W), .ACC_LEN(ACC_LEN), .OUT_W(40)) u_dut (
    .clk(clk), .reset(reset), .z_in(z_in), .in_valid(in_valid), .in_ready(in_ready),
    .clear(clear), .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .sat(sat), .grp_cnt(grp_cnt)
  );

  dsp_product_accumulator #(.IN_W(IN_W), .ACC_LEN(ACC_LEN), .OUT_W(38)) u_dut_narrow (
    .clk(clk), .reset(reset), .z_in(z_in), .in_valid(in_valid), .in_ready(in_ready_b),
    .clear(clear), .acc_out(acc_out_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .sat(sat_b), .grp_cnt(grp_cnt_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: running group sum and count, one pending output slot.
  logic [63:0] m_sum = '0;
  int          m_cnt = 0;
  logic        m_ov  = 1'b0;
  logic [63:0] m_out_a = '0, m_out_b = '0;
  logic        m_sat_a = 1'b0, m_sat_b = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic m_rdy(input logic ordy);
    return !(m_ov && !ordy && m_cnt == ACC_LEN - 1);
  endfunction

  function automatic logic [63:0] fit_model(input logic [63:0] s, input int w, output logic ovf);
    logic [63:0] maxv;
    logic        over;
    maxv = (64'd1 << w) - 64'd1;
    over = s > maxv;
`ifdef DSP_ACC_SAT_EN
    ovf = over;
    return over ? maxv : s;
`else
    ovf = 1'b0;
    return s & maxv;
`endif
  endfunction

  task automatic model_clock();
    logic acc;
    acc = in_valid && m_rdy(out_ready);
    if (m_ov && out_ready) m_ov = 1'b0;
    if (clear) begin
      m_cnt = 0;
      m_sum = '0;
    end
    if (acc) begin
      m_sum = m_sum + 64'(z_in);
      m_cnt++;
      if (m_cnt == ACC_LEN) begin
        m_ov    = 1'b1;
        m_out_a = fit_model(m_sum, 40, m_sat_a);
        m_out_b = fit_model(m_sum, 38, m_sat_b);
        m_cnt   = 0;
        m_sum   = '0;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", 64'(out_valid), 64'(m_ov));
    check_eq("out_valid_b", 64'(out_valid_b), 64'(m_ov));
    check_eq("grp_cnt", 64'(grp_cnt), 64'(m_cnt));
    check_eq("grp_cnt_b", 64'(grp_cnt_b), 64'(m_cnt));
    if (m_ov) begin
      check_eq("acc_out", 64'(acc_out), m_out_a);
      check_eq("acc_out_b", 64'(acc_out_b), m_out_b);
      check_eq("sat", 64'(sat), 64'(m_sat_a));
      check_eq("sat_b", 64'(sat_b), 64'(m_sat_b));
    end
  endtask

  task automatic step(input logic iv, input logic [IN_W-1:0] z, input logic clr,
                      input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    z_in      = z;
    clear     = clr;
    out_ready = ordy;
    #1;
    check_eq("in_ready", 64'(in_ready), 64'(m_rdy(ordy)));
    check_eq("in_ready_b", 64'(in_ready_b), 64'(m_rdy(ordy)));
    @(posedge clk);
    model_clock();
    #1;
    check_outputs();
  endtask

  task automatic check_reset_state();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_acc_out", 64'(acc_out), 64'd0);
    check_eq("rst_grp_cnt", 64'(grp_cnt), 64'd0);
    check_eq("rst_sat", 64'(sat), 64'd0);
    check_eq("rst_out_valid_b", 64'(out_valid_b), 64'd0);
    check_eq("rst_acc_out_b", 64'(acc_out_b), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_reset_state();
    m_ov = 1'b0; m_cnt = 0; m_sum = '0;
    m_out_a = '0; m_out_b = '0; m_sat_a = 1'b0; m_sat_b = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [IN_W-1:0] ones;
    logic [IN_W-1:0] z;
    ones = '1;

    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b1;

    // Basic group 1+2+3+4.
    for (int i = 1; i <= 4; i++) step(1'b1, IN_W'(i), 1'b0, 1'b1);
    check_eq("basic_sum", 64'(acc_out), 64'd10);
    check_eq("basic_valid", 64'(out_valid), 64'd1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Four maximal products.
    for (int i = 0; i < 4; i++) step(1'b1, ones, 1'b0, 1'b1);
    check_eq("max_sum", 64'(acc_out), 64'hFF_FFFF_FFFC);
    check_eq("max_sat", 64'(sat), 64'd0);
`ifdef DSP_ACC_SAT_EN
    check_eq("narrow_sum", 64'(acc_out_b), 64'h3F_FFFF_FFFF);
    check_eq("narrow_sat", 64'(sat_b), 64'd1);
`else
    check_eq("narrow_sum", 64'(acc_out_b), 64'h3F_FFFF_FFFC);
    check_eq("narrow_sat", 64'(sat_b), 64'd0);
`endif
    step(1'b0, '0, 1'b0, 1'b1);

    // Backpressure: group 1 waits while group 2 streams until its last product.
    for (int i = 1; i <= 3; i++) step(1'b1, IN_W'(i), 1'b0, 1'b1);
    step(1'b1, IN_W'(4), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, IN_W'(5), 1'b0, 1'b0);
    step(1'b1, IN_W'(5), 1'b0, 1'b0);
    step(1'b1, IN_W'(5), 1'b0, 1'b0);
    check_eq("bp_stall", 64'(in_ready), 64'd0);
    check_eq("bp_hold", 64'(acc_out), 64'd10);
    step(1'b1, IN_W'(5), 1'b0, 1'b1);
    check_eq("bp_refill", 64'(acc_out), 64'd20);
    step(1'b0, '0, 1'b0, 1'b1);

    // Clear discards the partial 7+7; the product accepted with it starts a group.
    step(1'b1, IN_W'(7), 1'b0, 1'b1);
    step(1'b1, IN_W'(7), 1'b0, 1'b1);
    step(1'b1, IN_W'(2), 1'b1, 1'b1);
    for (int i = 3; i <= 5; i++) step(1'b1, IN_W'(i), 1'b0, 1'b1);
    check_eq("clear_sum", 64'(acc_out), 64'd14);
    step(1'b0, '0, 1'b0, 1'b1);

    // Reset with a pending output and a partial group.
    for (int i = 0; i < 4; i++) step(1'b1, IN_W'(1), 1'b0, 1'b0);
    step(1'b1, IN_W'(9), 1'b0, 1'b0);
    step(1'b1, IN_W'(9), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, IN_W'(1), 1'b0, 1'b1);
    check_eq("reset_group", 64'(acc_out), 64'd4);
    step(1'b0, '0, 1'b0, 1'b1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       z = ones;
        1:       z = IN_W'($urandom_range(0, 255));
        default: z = IN_W'({$urandom(), $urandom()});
      endcase
      step($urandom_range(0, 3) != 0, z, $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0);
      if (n == 1500) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dsp_product_accumulator.md
Name: dsp_product_accumulator

Overview:
- Downstream stage of the registered-input multiplier; consumes its 38-bit unsigned product z_out.
- Sums ACC_LEN consecutive products into one group result.
- Presents each group result on a registered valid/ready output with one-deep buffering.
- Lets the multiplier stream continuously while the previous result waits for the consumer.

Parameters:
- IN_W, 38, product input width (matches the multiplier's z_out).
- ACC_LEN, 4, products per group; legal range 2..256.
- OUT_W, 40, result width; full-precision width is IN_W+$clog2(ACC_LEN) (localparam ACC_W).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- z_in  input  IN_W  unsigned product from the multiplier.
- in_valid  input  1  z_in is valid this cycle.
- in_ready  output  1  block accepts z_in this cycle (combinational).
- clear  input  1  synchronous; discards the partial group.
- acc_out  output  OUT_W  group result (registered).
- out_valid  output  1  acc_out is valid.
- out_ready  input  1  consumer takes acc_out.
- sat  output  1  acc_out was clamped (see Optional Feature).
- grp_cnt  output  $clog2(ACC_LEN)  products accepted in the current group.

Behaviour:
- Reset (reset=0, asynchronous): acc=0, grp_cnt=0, acc_out=0, out_valid=0, sat=0, state=IDLE.
- Accept condition: in_valid && in_ready.
- Accumulator width and extension:
  - acc is ACC_W bits; z_in is zero-extended.
  - First accept of a group: acc<=z_in.
  - Later accepts: acc<=acc+z_in.
  - No overflow inside acc by construction.
- grp_cnt increments on each accept; wraps to 0 on the ACC_LEN-th accept.
- Final accept (grp_cnt==ACC_LEN-1):
  - Next cycle: acc_out<=fit(acc+z_in) and out_valid=1.
  - Latency is 1 cycle from the final accept to out_valid.
- Output handshake:
  - out_valid deasserts the cycle after out_valid && out_ready.
  - acc_out and sat hold stable while out_valid && !out_ready.
- in_ready = !(out_valid && !out_ready && grp_cnt==ACC_LEN-1).
  - Only the final accept of the next group stalls.
  - The output register may be refilled in the same cycle it is drained.
- FSM state follows group progress:
  - IDLE: grp_cnt==0 and out_valid==0.
  - ACCUM: grp_cnt!=0.
  - PEND: out_valid==1 and grp_cnt==0.
  - Transitions:
    - IDLE->ACCUM on accept.
    - ACCUM->PEND on final accept.
    - PEND->IDLE on out_ready.
    - PEND->ACCUM on accept without out_ready.
- clear:
  - Sets grp_cnt=0; partial acc is discarded.
  - Does not touch out_valid, acc_out or sat.
- clear together with an accept: clear wins over the partial sum, and z_in starts a new group (acc=z_in, grp_cnt=1).
- Reset mid-group or with a pending output drops everything; no result is emitted.
- in_valid with in_ready=0: z_in is not consumed; the upstream stage holds it.

Optional Feature:
- Macro: DSP_ACC_SAT_EN.
- Defined:
  - fit() clamps to 2^OUT_W-1 when the ACC_W sum exceeds the OUT_W range.
  - sat=1 registered with that acc_out, else 0.
- Undefined:
  - fit() keeps the low OUT_W bits (wrap).
  - sat tied to 0.
- Both variants are identical when OUT_W>=ACC_W.

Decomposition:
- Package dsp_acc_pkg holds:
  - state enum {IDLE, ACCUM, PEND}.
  - function acc_width(in_w, len) returning in_w+$clog2(len).
- Sub-module dsp_acc_fit: combinational saturate-or-truncate from ACC_W to OUT_W; also produces the sat flag.

Test Plan:
- Basic group: ACC_LEN=4, z_in=1,2,3,4 back-to-back, out_ready=1 -> acc_out=10 and out_valid high one cycle after the 4th accept, grp_cnt back to 0.
- Max products: four z_in=2^38-1, OUT_W=40 -> acc_out=0xFF_FFFF_FFFC, sat=0.
- Saturation: same stimulus, OUT_W=38.
  - With DSP_ACC_SAT_EN -> acc_out=0x3F_FFFF_FFFF, sat=1.
  - Without -> acc_out=0x3F_FFFF_FFFC, sat=0.
- Backpressure: hold out_ready=0 after group 1 (sum 10), stream group 2 = 5,5,5,5.
  - in_ready drops only at the 4th 5.
  - acc_out stays 10.
  - Release out_ready -> 10 taken, then 20 appears the next cycle.
- Clear: feed 7,7, then pulse clear with z_in=2 accepted, then 3,4,5 -> acc_out=14, earlier 7s discarded.
- Reset mid-operation: assert reset after 2 accepts and with a pending output -> out_valid=0, acc_out=0, grp_cnt=0 immediately. A fresh group 1,1,1,1 then gives acc_out=4.
